// File: rtl/loader_pkg.sv
// Shared types and constants for the SDRAM -> M9K buffer loader.
package loader_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        DONE
    } state_t;

    localparam int BUF_WORDS          = 512;
    localparam int BUF_AW             = 9;
    localparam int DEF_BURST_LEN      = 8;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_ADDR_W         = 24;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: expires after TIMEOUT_CYCLES enabled cycles without a clear.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = en_i && !clr_i
                    && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_m9k_loader.sv
// Burst-reads SDRAM and fills the 512x16 M9K buffer from word 0.
// Optional LOADER_CHECKSUM_EN adds a wrapping 16-bit sum of written words.
module sdram_m9k_loader
    import loader_pkg::*;
#(
    parameter int BURST_LEN      = DEF_BURST_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base_addr,
    input  logic [9:0]        word_count,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic              sdram_rd_ack,
    input  logic              sdram_rd_valid,
    input  logic [15:0]       sdram_rd_data,
    output logic              WR,
    output logic [BUF_AW-1:0] wr_address_word,
    output logic [15:0]       wr_data_word,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       checksum
);

    localparam int         BCW       = $clog2(BURST_LEN) + 1;
    localparam logic [9:0] MAX_WORDS = 10'(BUF_WORDS);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [9:0]          count_q;
    logic [9:0]          ptr_q;
    logic [9:0]          ptr_d;
    logic [BCW-1:0]      burst_q;
    logic                req_q;
    logic                wr_q;
    logic [BUF_AW-1:0]   wr_addr_q;
    logic [15:0]         wr_data_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;
    logic                wr_en_d;
    logic                expired;
    logic                to_en;
    logic                to_clr;

    assign to_en  = (state_q == WAIT_DATA);
    assign to_clr = !to_en || sdram_rd_valid;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (CLOCK_50),
        .rst_i    (RESET),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .expired_o(expired)
    );

    // Words past the requested count are still consumed from the burst.
    always_comb begin
        wr_en_d = to_en && sdram_rd_valid && (ptr_q < count_q);
        ptr_d   = ptr_q + {9'd0, wr_en_d};
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            count_q   <= '0;
            ptr_q     <= '0;
            burst_q   <= '0;
            req_q     <= 1'b0;
            wr_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q  <= src_base_addr;
                        count_q <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                        if (word_count == 10'd0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (sdram_rd_ack) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT_DATA;
                        burst_q <= BCW'(BURST_LEN);
                        addr_q  <= addr_q + ADDR_W'(BURST_LEN);
                    end
                end
                WAIT_DATA: begin
                    if (expired) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else if (sdram_rd_valid) begin
                        burst_q <= burst_q - BCW'(1);
                        ptr_q   <= ptr_d;
                        if (wr_en_d) begin
                            wr_q      <= 1'b1;
                            wr_addr_q <= ptr_q[BUF_AW-1:0];
                            wr_data_q <= sdram_rd_data;
                        end
                        if (burst_q == BCW'(1)) begin
                            if (ptr_d == count_q) begin
                                state_q <= DONE;
                            end else begin
                                state_q <= REQ;
                                req_q   <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sum_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            sum_q <= '0;
        end else if (wr_en_d) begin
            sum_q <= sum_q + sdram_rd_data;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

    assign sdram_rd_req    = req_q;
    assign sdram_rd_addr   = addr_q;
    assign WR              = wr_q;
    assign wr_address_word = wr_addr_q;
    assign wr_data_word    = wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: tb/tb_sdram_m9k_loader.sv
// Directed bench for sdram_m9k_loader with a queue-based write/request model.
module tb_sdram_m9k_loader;

    localparam int BL = 8;

    logic        CLOCK_50 = 1'b0;
    logic        RESET = 1'b1;
    logic        start = 1'b0;
    logic [23:0] src_base_addr = '0;
    logic [9:0]  word_count = '0;
    logic        sdram_rd_req;
    logic [23:0] sdram_rd_addr;
    logic        sdram_rd_ack = 1'b0;
    logic        sdram_rd_valid = 1'b0;
    logic [15:0] sdram_rd_data = '0;
    logic        WR;
    logic [8:0]  wr_address_word;
    logic [15:0] wr_data_word;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    sdram_m9k_loader #(
        .BURST_LEN(BL),
        .TIMEOUT_CYCLES(1024),
        .ADDR_W(24)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .RESET          (RESET),
        .start          (start),
        .src_base_addr  (src_base_addr),
        .word_count     (word_count),
        .sdram_rd_req   (sdram_rd_req),
        .sdram_rd_addr  (sdram_rd_addr),
        .sdram_rd_ack   (sdram_rd_ack),
        .sdram_rd_valid (sdram_rd_valid),
        .sdram_rd_data  (sdram_rd_data),
        .WR             (WR),
        .wr_address_word(wr_address_word),
        .wr_data_word   (wr_data_word),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .checksum       (checksum)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [8:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         wq[$];
    logic [23:0] rq[$];
    logic [15:0] msum;
    logic [15:0] log_data [0:511];
    logic [23:0] req_log [0:7];
    int          n_chk = 0;
    int          n_fail = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          last_wr_addr = -1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    function automatic logic [15:0] mem(input logic [23:0] a);
        if (a == 24'h200) return 16'hFFFF;
        if (a == 24'h201) return 16'h0002;
        return 16'(a * 24'h1357 + 24'hA5C3);
    endfunction

    function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef LOADER_CHECKSUM_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    task automatic model_setup(input logic [23:0] base, input int cnt);
        int n;
        n = (cnt > 512) ? 512 : cnt;
        wq.delete();
        rq.delete();
        msum = '0;
        for (int i = 0; i < n; i++) begin
            wq.push_back('{a: 9'(i), d: mem(base + 24'(i))});
            msum = msum + mem(base + 24'(i));
        end
        for (int k = 0; k * BL < n; k++) rq.push_back(base + 24'(k * BL));
    endtask

    task automatic monitor();
        logic        prev_req = 1'b0;
        logic [23:0] prev_addr = '0;
        wr_t         e;
        forever begin
            @(negedge CLOCK_50);
            if (WR) begin
                if (wq.size() == 0) begin
                    note_fail("WR not expected by model");
                end else begin
                    e = wq.pop_front();
                    chk("wr addr", 32'(wr_address_word), 32'(e.a));
                    chk("wr data", 32'(wr_data_word), 32'(e.d));
                end
                log_data[wr_address_word] = wr_data_word;
                last_wr_addr = int'(wr_address_word);
                wr_cnt++;
            end
            if (sdram_rd_req && !prev_req) begin
                if (rq.size() == 0) note_fail("req not expected by model");
                else chk("req addr", 32'(sdram_rd_addr), 32'(rq.pop_front()));
            end
            if (sdram_rd_req && prev_req)
                chk("req addr stable", 32'(sdram_rd_addr), 32'(prev_addr));
            if (done) begin
                done_cnt++;
                chk("done: writes pending", 32'(wq.size()), 0);
                chk("done: reqs pending", 32'(rq.size()), 0);
                chk("done: busy", 32'(busy), 0);
                chk("done: checksum", 32'(checksum), 32'(exp_sum(msum)));
            end
            if (error) begin
                err_cnt++;
                chk("error: busy", 32'(busy), 0);
            end
            prev_req = sdram_rd_req;
            prev_addr = sdram_rd_addr;
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_start(input logic [23:0] base, input int cnt);
        src_base_addr = base;
        word_count = 10'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 20 && !sdram_rd_req; i++) tick();
        chk("req seen", 32'(sdram_rd_req), 1);
    endtask

    task automatic run_load(input logic [23:0] base, input int cnt, input bit gaps,
                            input bit poke, output int nreq, output int nval,
                            output int ncyc);
        int          d0;
        int          e0;
        bit          fin;
        logic [23:0] a;
        model_setup(base, cnt);
        d0 = done_cnt;
        e0 = err_cnt;
        nreq = 0;
        nval = 0;
        fin = 1'b0;
        pulse_start(base, cnt);
        ncyc = 1;
        chk("busy after start", 32'(busy), 1);
        while (!fin && ncyc < 2000) begin
            if (done || error) begin
                fin = 1'b1;
            end else if (sdram_rd_req) begin
                a = sdram_rd_addr;
                if (nreq < 8) req_log[nreq] = a;
                nreq++;
                sdram_rd_ack = 1'b1;
                tick();
                ncyc++;
                sdram_rd_ack = 1'b0;
                for (int k = 0; k < BL; k++) begin
                    sdram_rd_valid = 1'b1;
                    sdram_rd_data = mem(a + 24'(k));
                    nval++;
                    if (poke && nreq == 1 && k == 0) begin
                        start = 1'b1;
                        word_count = 10'd3;
                        src_base_addr = 24'h777;
                    end
                    tick();
                    ncyc++;
                    sdram_rd_valid = 1'b0;
                    start = 1'b0;
                    if (gaps && (k % 3 == 1)) begin
                        tick();
                        ncyc++;
                    end
                end
            end else begin
                tick();
                ncyc++;
            end
        end
        if (!fin) $display("FAIL load bound expired: got %0d cycles", ncyc);
        chk("load finished", 32'(fin), 1);
        @(negedge CLOCK_50);
        #1;
        chk("one done", 32'(done_cnt - d0), 1);
        chk("no error", 32'(err_cnt - e0), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq, nval, ncyc, w0, d0, e0, k;
        fork
            monitor();
        join_none

        repeat (3) tick();
        chk("rst req", 32'(sdram_rd_req), 0);
        chk("rst addr", 32'(sdram_rd_addr), 0);
        chk("rst WR", 32'(WR), 0);
        chk("rst wr addr", 32'(wr_address_word), 0);
        chk("rst wr data", 32'(wr_data_word), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst error", 32'(error), 0);
        chk("rst checksum", 32'(checksum), 0);
        RESET = 1'b0;
        tick();

        // Two full bursts
        w0 = wr_cnt;
        run_load(24'h000100, 16, 1'b0, 1'b0, nreq, nval, ncyc);
        chk("t16 nreq", 32'(nreq), 2);
        chk("t16 req0", 32'(req_log[0]), 32'h100);
        chk("t16 req1", 32'(req_log[1]), 32'h108);
        chk("t16 writes", 32'(wr_cnt - w0), 16);
        chk("t16 word0", 32'(log_data[0]), 32'hFCC3);
        chk("t16 word15", 32'(log_data[15]), 32'h1EDC);
        chk("t16 last addr", 32'(last_wr_addr), 15);

        // Partial burst with gaps, start pulsed while busy
        w0 = wr_cnt;
        run_load(24'h000040, 5, 1'b1, 1'b1, nreq, nval, ncyc);
        chk("t5 nreq", 32'(nreq), 1);
        chk("t5 nvalid", 32'(nval), 8);
        chk("t5 writes", 32'(wr_cnt - w0), 5);
        chk("t5 last addr", 32'(last_wr_addr), 4);

        // Zero-length load
        w0 = wr_cnt;
        run_load(24'h000900, 0, 1'b0, 1'b0, nreq, nval, ncyc);
        chk("t0 done latency", 32'(ncyc), 2);
        chk("t0 nreq", 32'(nreq), 0);
        chk("t0 writes", 32'(wr_cnt - w0), 0);

        // Checksum with wrap
        run_load(24'h000200, 2, 1'b0, 1'b0, nreq, nval, ncyc);
`ifdef LOADER_CHECKSUM_EN
        chk("checksum wrap", 32'(checksum), 32'h0001);
`else
        chk("checksum tied", 32'(checksum), 32'h0000);
`endif

        // Oversized count clamps to the buffer
        w0 = wr_cnt;
        run_load(24'h001000, 1023, 1'b0, 1'b0, nreq, nval, ncyc);
        chk("clamp nreq", 32'(nreq), 64);
        chk("clamp writes", 32'(wr_cnt - w0), 512);
        chk("clamp last addr", 32'(last_wr_addr), 511);

        // Timeout after ack with no data
        model_setup(24'h000300, 8);
        wq.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        pulse_start(24'h000300, 8);
        wait_req();
        sdram_rd_ack = 1'b1;
        tick();
        sdram_rd_ack = 1'b0;
        k = 0;
        while (!error && k < 1100) begin
            if (k == 500) chk("timeout busy", 32'(busy), 1);
            tick();
            k++;
        end
        chk("timeout seen", 32'(error), 1);
        chk("timeout window", 32'(k >= 1024 && k <= 1026), 1);
        @(negedge CLOCK_50);
        #1;
        chk("timeout one error", 32'(err_cnt - e0), 1);
        chk("timeout no done", 32'(done_cnt - d0), 0);

        // Reset in the middle of a burst
        model_setup(24'h000400, 16);
        d0 = done_cnt;
        pulse_start(24'h000400, 16);
        wait_req();
        sdram_rd_ack = 1'b1;
        tick();
        sdram_rd_ack = 1'b0;
        for (int j = 0; j < BL; j++) begin
            if (j == 3) RESET = 1'b1;
            if (j == 4) begin
                RESET = 1'b0;
                wq.delete();
                rq.delete();
            end
            sdram_rd_valid = 1'b1;
            sdram_rd_data = mem(24'h400 + 24'(j));
            tick();
        end
        sdram_rd_valid = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk("post-rst req", 32'(sdram_rd_req), 0);
            chk("post-rst busy", 32'(busy), 0);
            tick();
        end
        chk("post-rst no done", 32'(done_cnt - d0), 0);
        w0 = wr_cnt;
        run_load(24'h000500, 3, 1'b1, 1'b0, nreq, nval, ncyc);
        chk("restart writes", 32'(wr_cnt - w0), 3);
        chk("restart req0", 32'(req_log[0]), 32'h500);

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
